// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: access FSM states and the port grant encoding.
package sram_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // Which master owns the current access.
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    // The SRAM has a low and a high byte lane.
    localparam int BYTE_LANES = 2;

endpackage

// File: rtl/sram_arb_chk.sv
// Simulation-only protocol checks for the SRAM arbiter's port B.
module sram_arb_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_b_read,
    input logic i_b_write
);

    // A simultaneous read and write on B is resolved as a write; it is still a master bug.
    property p_b_not_both;
        @(posedge i_clk) disable iff (!i_rst_n) !(i_b_read && i_b_write);
    endproperty

    a_b_not_both: assert property (p_b_not_both);

endmodule

// File: rtl/sram_arb_grant.sv
// Grant decision between the fixed-priority pixel reader (A) and the CPU port (B).
// B is forced through once A has won B_MAX_WAIT times in a row while B was waiting.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int B_MAX_WAIT = 4,
    parameter int STARVE_W   = $clog2(B_MAX_WAIT + 1)
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_idle,
    input  logic   i_a_req,
    input  logic   i_b_req,
    output logic   o_gnt_valid,
    output grant_t o_gnt
);

    generate
        if (B_MAX_WAIT < 1) begin : g_bad_b_max_wait
            $error("sram_arb_grant: B_MAX_WAIT must be at least 1");
        end
    endgenerate

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(B_MAX_WAIT);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_force_b;

    // Decide which port, if any, may start an access this cycle.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt       = GNT_A;
        w_force_b   = i_b_req && (r_starve_cnt == STARVE_MAX);
        if (!i_idle) begin
            o_gnt_valid = 1'b0;
            o_gnt       = GNT_A;
        end else if (i_a_req && !w_force_b) begin
            o_gnt_valid = 1'b1;
            o_gnt       = GNT_A;
        end else if (i_b_req) begin
            o_gnt_valid = 1'b1;
            o_gnt       = GNT_B;
        end else begin
            o_gnt_valid = 1'b0;
            o_gnt       = GNT_A;
        end
    end

    // Count A wins while B waits; any B win clears the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (i_idle && o_gnt_valid) begin
            if (o_gnt == GNT_B) begin
                r_starve_cnt <= {STARVE_W{1'b0}};
            end else if (i_b_req && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for the off-chip 16-bit asynchronous SRAM.
// Port A (pixel reader) is read-only with fixed priority; port B (CPU) reads and writes.
// All SRAM pins and read responses come straight from registers.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2,
    parameter int B_MAX_WAIT    = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  a_read,
    input  logic [ADDR_W-1:0]     a_address,
    output logic                  a_waitrequest,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W-1:0]     b_writedata,
    input  logic [BYTE_LANES-1:0] b_byteenable,
    output logic                  b_waitrequest,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    inout  wire  [DATA_W-1:0]     sram_DQ,
    output logic [ADDR_W-1:0]     sram_ADDR,
    output logic                  sram_LB_N,
    output logic                  sram_UB_N,
    output logic                  sram_CE_N,
    output logic                  sram_OE_N,
    output logic                  sram_WE_N
);

    generate
        if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
            $error("sram_arbiter: ACCESS_CYCLES must be at least 1");
        end
    endgenerate

    localparam int              CNT_W    = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    grant_t              r_port;
    logic                w_gnt_valid;
    grant_t              w_gnt;
    logic                w_is_write;
    logic                w_idle;
    logic                w_b_req;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_lb_n;
    logic                r_ub_n;
    logic                r_dq_oe;
    logic [DATA_W-1:0]   r_dq_out;
    logic [DATA_W-1:0]   r_a_rdata;
    logic [DATA_W-1:0]   r_b_rdata;
    logic                r_a_rdv;
    logic                r_b_rdv;

    assign w_idle  = (r_state == IDLE);
    assign w_b_req = b_read | b_write;

    sram_arb_grant #(
        .B_MAX_WAIT (B_MAX_WAIT)
    ) u_grant (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_idle      (w_idle),
        .i_a_req     (a_read),
        .i_b_req     (w_b_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    sram_arb_chk u_chk (
        .i_clk     (clk_clk),
        .i_rst_n   (reset_reset_n),
        .i_b_read  (b_read),
        .i_b_write (b_write)
    );

    // Port B with both strobes set is handled as a write.
    assign w_is_write = (w_gnt == GNT_B) && b_write;

    // Accept handshakes: only the port granted in IDLE sees waitrequest low.
    always_comb begin
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        if (w_gnt_valid && (w_gnt == GNT_A)) begin
            a_waitrequest = 1'b0;
        end else if (w_gnt_valid && (w_gnt == GNT_B)) begin
            b_waitrequest = 1'b0;
        end else begin
            a_waitrequest = 1'b1;
            b_waitrequest = 1'b1;
        end
    end

    // Access sequencer state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: READ/WRITE last ACCESS_CYCLES cycles; writes add one RECOVER cycle for data hold.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_cnt_nxt = CNT_W'(1);
                    if (w_is_write) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            READ: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = READ;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RECOVER;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = WRITE;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            RECOVER: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pin and response registers: launch strobes on grant, release them when the access ends.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_addr    <= {ADDR_W{1'b0}};
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_lb_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_dq_oe   <= 1'b0;
            r_dq_out  <= {DATA_W{1'b0}};
            r_a_rdata <= {DATA_W{1'b0}};
            r_b_rdata <= {DATA_W{1'b0}};
            r_a_rdv   <= 1'b0;
            r_b_rdv   <= 1'b0;
            r_port    <= GNT_A;
        end else begin
            r_a_rdv <= 1'b0;
            r_b_rdv <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_port <= w_gnt;
                        r_addr <= (w_gnt == GNT_A) ? a_address : b_address;
                        r_ce_n <= 1'b0;
                        if (w_is_write) begin
                            r_oe_n   <= 1'b1;
                            r_we_n   <= 1'b0;
                            r_lb_n   <= ~b_byteenable[0];
                            r_ub_n   <= ~b_byteenable[1];
                            r_dq_oe  <= 1'b1;
                            r_dq_out <= b_writedata;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_we_n  <= 1'b1;
                            r_lb_n  <= 1'b0;
                            r_ub_n  <= 1'b0;
                            r_dq_oe <= 1'b0;
                        end
                    end else begin
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end
                end
                READ: begin
                    if (r_cnt == CNT_LAST) begin
                        if (r_port == GNT_A) begin
                            r_a_rdata <= sram_DQ;
                            r_a_rdv   <= 1'b1;
                        end else begin
                            r_b_rdata <= sram_DQ;
                            r_b_rdv   <= 1'b1;
                        end
                        r_ce_n <= 1'b1;
                        r_oe_n <= 1'b1;
                        r_lb_n <= 1'b1;
                        r_ub_n <= 1'b1;
                    end
                end
                WRITE: begin
                    // Strobes rise at the end of the access; address and data stay for RECOVER.
                    if (r_cnt == CNT_LAST) begin
                        r_ce_n <= 1'b1;
                        r_we_n <= 1'b1;
                        r_lb_n <= 1'b1;
                        r_ub_n <= 1'b1;
                    end
                end
                RECOVER: begin
                    r_dq_oe <= 1'b0;
                end
                default: begin
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    assign sram_DQ         = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
    assign sram_ADDR       = r_addr;
    assign sram_CE_N       = r_ce_n;
    assign sram_OE_N       = r_oe_n;
    assign sram_WE_N       = r_we_n;
    assign sram_LB_N       = r_lb_n;
    assign sram_UB_N       = r_ub_n;
    assign a_readdata      = r_a_rdata;
    assign a_readdatavalid = r_a_rdv;
    assign b_readdata      = r_b_rdata;
    assign b_readdatavalid = r_b_rdv;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM (256 words, low address byte indexed).
module tb_sram_arbiter;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        a_read;
    logic [19:0] a_address;
    logic        a_waitrequest;
    logic [15:0] a_readdata;
    logic        a_readdatavalid;
    logic        b_read;
    logic        b_write;
    logic [19:0] b_address;
    logic [15:0] b_writedata;
    logic [1:0]  b_byteenable;
    logic        b_waitrequest;
    logic [15:0] b_readdata;
    logic        b_readdatavalid;
    wire  [15:0] sram_DQ;
    logic [19:0] sram_ADDR;
    logic        sram_LB_N;
    logic        sram_UB_N;
    logic        sram_CE_N;
    logic        sram_OE_N;
    logic        sram_WE_N;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;

    logic [15:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    sram_arbiter dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .a_read          (a_read),
        .a_address       (a_address),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .b_read          (b_read),
        .b_write         (b_write),
        .b_address       (b_address),
        .b_writedata     (b_writedata),
        .b_byteenable    (b_byteenable),
        .b_waitrequest   (b_waitrequest),
        .b_readdata      (b_readdata),
        .b_readdatavalid (b_readdatavalid),
        .sram_DQ         (sram_DQ),
        .sram_ADDR       (sram_ADDR),
        .sram_LB_N       (sram_LB_N),
        .sram_UB_N       (sram_UB_N),
        .sram_CE_N       (sram_CE_N),
        .sram_OE_N       (sram_OE_N),
        .sram_WE_N       (sram_WE_N)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // SRAM model: drives DQ while selected for read, stores enabled lanes while WE_N is low.
    assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? mem[sram_ADDR[7:0]] : 16'hzzzz;

    always @(posedge clk_clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!sram_CE_N && !sram_WE_N) begin
            if (!sram_LB_N) mem[sram_ADDR[7:0]][7:0]  <= sram_DQ[7:0];
            if (!sram_UB_N) mem[sram_ADDR[7:0]][15:8] <= sram_DQ[15:8];
        end
    end

    // Bus contention watch: arbiter driving DQ while the SRAM output is enabled.
    always @(negedge clk_clk) begin
        if (dut.r_dq_oe && !sram_OE_N) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] addr, input logic [15:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        @(negedge clk_clk);
        pre_en   = 1'b0;
    endtask

    typedef struct {
        logic        is_b;
        logic        is_wr;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        pre;
        logic [15:0] preval;
        logic [15:0] exp_rd;
        logic        exp_lb_n;
        logic        exp_ub_n;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] last_a;
    int          a_grants;
    int          grants_at_b;
    logic        b_done;
    logic        got;
    logic        seen_rdv;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           is_b  wr    addr       wdata     be     pre   preval    exp_rd    lb    ub    exp_mem
        tbl[0] = '{1'b0, 1'b0, 20'h12345, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 20'h00010, 16'hA55A, 2'b01, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h125A};
        tbl[2] = '{1'b1, 1'b1, 20'h00020, 16'h7788, 2'b10, 1'b1, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 16'h77AA};
        tbl[3] = '{1'b1, 1'b1, 20'h00030, 16'hFFFF, 2'b00, 1'b1, 16'h1111, 16'h0000, 1'b1, 1'b1, 16'h1111};
        tbl[4] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h125A, 1'b0, 1'b0, 16'h125A};
        tbl[5] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h77AA, 1'b0, 1'b0, 16'h77AA};

        reset_reset_n = 1'b0;
        a_read = 1'b0; a_address = 20'h0;
        b_read = 1'b0; b_write = 1'b0; b_address = 20'h0;
        b_writedata = 16'h0; b_byteenable = 2'b00;
        pre_en = 1'b0; pre_addr = 8'h0; pre_data = 16'h0;
        last_a = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk_clk);
        chk("rst_ce_n", {31'd0, sram_CE_N}, 32'd1);
        chk("rst_strobes", {27'd0, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N, 1'b1}, 32'h1F);
        chk("rst_addr", {12'd0, sram_ADDR}, 32'h0);
        chk("rst_dq_oe", {31'd0, dut.r_dq_oe}, 32'd0);
        chk("rst_rdv", {30'd0, a_readdatavalid, b_readdatavalid}, 32'd0);
        chk("rst_rdata", {a_readdata, b_readdata}, 32'h0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Table: single accesses, each walked cycle by cycle
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].pre) preload(tbl[r].addr[7:0], tbl[r].preval);
            if (tbl[r].is_b) begin
                b_address    = tbl[r].addr;
                b_writedata  = tbl[r].wdata;
                b_byteenable = tbl[r].be;
                b_write      = tbl[r].is_wr;
                b_read       = !tbl[r].is_wr;
            end else begin
                a_address = tbl[r].addr;
                a_read    = 1'b1;
            end
            #1;
            chk($sformatf("r%0d_wait", r), {31'd0, tbl[r].is_b ? b_waitrequest : a_waitrequest}, 32'd0);
            @(negedge clk_clk);
            a_read = 1'b0; b_read = 1'b0; b_write = 1'b0;
            for (int c = 1; c <= 2; c++) begin
                chk($sformatf("r%0d_c%0d_ce", r, c), {31'd0, sram_CE_N}, 32'd0);
                chk($sformatf("r%0d_c%0d_addr", r, c), {12'd0, sram_ADDR}, {12'd0, tbl[r].addr});
                if (tbl[r].is_wr)
                    chk($sformatf("r%0d_c%0d_pins", r, c), {28'd0, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N},
                        {28'd0, 1'b1, 1'b0, tbl[r].exp_lb_n, tbl[r].exp_ub_n});
                else
                    chk($sformatf("r%0d_c%0d_pins", r, c), {28'd0, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N},
                        {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
                @(negedge clk_clk);
            end
            if (!tbl[r].is_wr) begin
                if (tbl[r].is_b) begin
                    chk($sformatf("r%0d_b_rdv", r), {30'd0, b_readdatavalid, a_readdatavalid}, 32'd2);
                    chk($sformatf("r%0d_b_rdata", r), {16'd0, b_readdata}, {16'd0, tbl[r].exp_rd});
                    chk($sformatf("r%0d_a_hold", r), {16'd0, a_readdata}, {16'd0, last_a});
                end else begin
                    chk($sformatf("r%0d_a_rdv", r), {30'd0, a_readdatavalid, b_readdatavalid}, 32'd2);
                    chk($sformatf("r%0d_a_rdata", r), {16'd0, a_readdata}, {16'd0, tbl[r].exp_rd});
                    last_a = tbl[r].exp_rd;
                end
                chk($sformatf("r%0d_release", r), {30'd0, sram_CE_N, sram_OE_N}, 32'd3);
            end else begin
                chk($sformatf("r%0d_recover", r), {29'd0, sram_CE_N, sram_WE_N, sram_OE_N}, 32'd7);
                chk($sformatf("r%0d_hold_oe", r), {31'd0, dut.r_dq_oe}, 32'd1);
                chk($sformatf("r%0d_hold_dq", r), {16'd0, sram_DQ}, {16'd0, tbl[r].wdata});
                @(negedge clk_clk);
                chk($sformatf("r%0d_dq_off", r), {31'd0, dut.r_dq_oe}, 32'd0);
                chk($sformatf("r%0d_mem", r), {16'd0, mem[tbl[r].addr[7:0]]}, {16'd0, tbl[r].exp_mem});
            end
        end

        // A read and B write in the same cycle: A first, B accepted three cycles later
        a_address = 20'h12345; a_read = 1'b1;
        b_address = 20'h00050; b_writedata = 16'h1357; b_byteenable = 2'b11; b_write = 1'b1;
        #1;
        chk("t3_a_wait", {30'd0, a_waitrequest, b_waitrequest}, 32'd1);
        @(negedge clk_clk);
        a_read = 1'b0;
        chk("t3_b_wait_c1", {31'd0, b_waitrequest}, 32'd1);
        @(negedge clk_clk);
        chk("t3_b_wait_c2", {31'd0, b_waitrequest}, 32'd1);
        @(negedge clk_clk);
        chk("t3_a_rdv_c3", {31'd0, a_readdatavalid}, 32'd1);
        chk("t3_b_wait_c3", {31'd0, b_waitrequest}, 32'd0);
        @(negedge clk_clk);
        b_write = 1'b0;
        chk("t3_b_we_c4", {30'd0, sram_CE_N, sram_WE_N}, 32'd0);
        repeat (3) @(negedge clk_clk);
        chk("t3_mem", {16'd0, mem[8'h50]}, 32'h1357);

        // Starvation: A reads continuously with B read pending
        a_address = 20'h12345; a_read = 1'b1;
        b_address = 20'h00010; b_read = 1'b1;
        a_grants = 0; grants_at_b = -1; b_done = 1'b0;
        for (int c = 0; c < 60 && !b_done; c++) begin
            #1;
            if (a_read && !a_waitrequest) a_grants++;
            if (b_read && !b_waitrequest) begin
                b_done = 1'b1;
                grants_at_b = a_grants;
            end
            @(negedge clk_clk);
        end
        a_read = 1'b0; b_read = 1'b0;
        chk("t4_b_granted", {31'd0, b_done}, 32'd1);
        chk("t4_a_grants", grants_at_b, 32'd4);
        chk("t4_starve_clr", {29'd0, dut.u_grant.r_starve_cnt}, 32'd0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (b_readdatavalid) got = 1'b1;
            else @(negedge clk_clk);
        end
        chk("t4_b_rdv", {31'd0, got}, 32'd1);
        chk("t4_b_rdata", {16'd0, b_readdata}, 32'h125A);
        chk("t4_a_quiet", {31'd0, a_readdatavalid}, 32'd0);
        chk("t4_a_hold", {16'd0, a_readdata}, 32'hBEEF);
        @(negedge clk_clk);

        // B write then B read of the same address back to back
        b_address = 20'h00040; b_writedata = 16'h5A5A; b_byteenable = 2'b11; b_write = 1'b1;
        @(negedge clk_clk);
        b_write = 1'b0; b_read = 1'b1;
        chk("t5_we_c1", {31'd0, sram_WE_N}, 32'd0);
        @(negedge clk_clk);
        @(negedge clk_clk);
        chk("t5_recover", {28'd0, sram_CE_N, sram_WE_N, sram_OE_N, dut.r_dq_oe}, 32'hF);
        chk("t5_b_wait_rec", {31'd0, b_waitrequest}, 32'd1);
        @(negedge clk_clk);
        chk("t5_b_wait_idle", {31'd0, b_waitrequest}, 32'd0);
        @(negedge clk_clk);
        b_read = 1'b0;
        chk("t5_read_pins", {30'd0, sram_OE_N, dut.r_dq_oe}, 32'd0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (b_readdatavalid) got = 1'b1;
            else @(negedge clk_clk);
        end
        chk("t5_b_rdv", {31'd0, got}, 32'd1);
        chk("t5_b_rdata", {16'd0, b_readdata}, 32'h5A5A);
        @(negedge clk_clk);

        // Reset asserted in read cycle 1
        a_address = 20'h12345; a_read = 1'b1;
        @(negedge clk_clk);
        a_read = 1'b0;
        chk("t6_ce_before", {31'd0, sram_CE_N}, 32'd0);
        reset_reset_n = 1'b0;
        #1;
        chk("t6_strobes", {29'd0, sram_CE_N, sram_OE_N, dut.r_dq_oe}, 32'd6);
        chk("t6_rdata", {16'd0, a_readdata}, 32'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        seen_rdv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (a_readdatavalid || b_readdatavalid) seen_rdv = 1'b1;
            @(negedge clk_clk);
        end
        chk("t6_no_rdv", {31'd0, seen_rdv}, 32'd0);
        chk("no_dq_overlap", overlap_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
